// File: rtl/cpu_exec_unit.sv
// Single-clock CPU execution unit: A/X/Y/S/P register file and one micro-op at a time
// over a valid/ready handshake, sequenced IDLE -> EXEC -> (DADJ) -> WB.
module cpu_exec_unit #(
   parameter int DW         = 8,
   parameter bit DECIMAL_EN = 1'b0
) (
   input  logic          clk_ph1,
   input  logic          rst,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [3:0]    op_code,
   input  logic [1:0]    op_src,
   input  logic [1:0]    op_dst,
   input  logic [DW-1:0] op_operand,
   output logic          op_done,
   output logic          op_err,
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] x_out,
   output logic [DW-1:0] y_out,
   output logic [DW-1:0] s_out,
   output logic [7:0]    p_out
);

   localparam logic [3:0] OP_LD  = 4'd0;
   localparam logic [3:0] OP_TR  = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_ORA = 4'd5;
   localparam logic [3:0] OP_EOR = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;
   localparam logic [3:0] OP_ASL = 4'd8;
   localparam logic [3:0] OP_LSR = 4'd9;
   localparam logic [3:0] OP_ROL = 4'd10;
   localparam logic [3:0] OP_ROR = 4'd11;
   localparam logic [3:0] OP_INC = 4'd12;
   localparam logic [3:0] OP_DEC = 4'd13;
   localparam logic [3:0] OP_FLG = 4'd14;
   localparam logic [3:0] OP_RSV = 4'd15;

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DADJ, ST_WB} state_t;

   state_t        r_state;
   logic [DW-1:0] r_a, r_x, r_y, r_s;
   logic [7:0]    r_p;
   logic [3:0]    r_code;
   logic [1:0]    r_src, r_dst;
   logic [DW-1:0] r_opnd;
   logic [DW-1:0] r_res;
   logic          r_c, r_v;
   logic          r_done, r_err;

   logic [DW-1:0] w_src_val, w_dst_val, w_addend, w_res;
   logic [DW:0]   w_sum, w_bcd;
   logic          w_c, w_v, w_dec_go;
   logic          w_wr_en, w_nz_en, w_c_en, w_v_en;
   logic [1:0]    w_wr_sel;

   // Nibble-serial BCD add/subtract; returns {carry, result}. Carry=1 means no borrow on subtract.
   function automatic logic [DW:0] bcd_adj(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic cin, input logic sub);
      logic [DW-1:0] res;
      logic          c;
      logic [4:0]    t;
      res = '0;
      c   = cin;
      for (int i = 0; i < DW / 4; i++) begin
         if (sub) begin
            t = {1'b0, a[4*i +: 4]} + {1'b0, ~b[4*i +: 4]} + {4'd0, c};
            if (t[4]) begin
               res[4*i +: 4] = t[3:0];
               c = 1'b1;
            end else begin
               res[4*i +: 4] = t[3:0] - 4'd6;
               c = 1'b0;
            end
         end else begin
            t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (t > 5'd9) begin
               t = t + 5'd6;
               c = 1'b1;
            end else begin
               c = 1'b0;
            end
            res[4*i +: 4] = t[3:0];
         end
      end
      return {c, res};
   endfunction

   assign op_ready = (r_state == ST_IDLE) && rst;
   assign op_done  = r_done;
   assign op_err   = r_err;
   assign a_out    = r_a;
   assign x_out    = r_x;
   assign y_out    = r_y;
   assign s_out    = r_s;
   assign p_out    = {r_p[7:6], 1'b1, r_p[4:0]};

   // SBC is ADC of the one's complement, so both share one adder
   assign w_addend = (r_code == OP_SBC) ? ~r_opnd : r_opnd;
   assign w_sum    = {1'b0, r_a} + {1'b0, w_addend} + {{DW{1'b0}}, r_p[0]};
   assign w_bcd    = bcd_adj(r_a, r_opnd, r_p[0], r_code == OP_SBC);
   assign w_dec_go = DECIMAL_EN && r_p[3] && ((r_code == OP_ADC) || (r_code == OP_SBC));

   // Operand register read ports
   always_comb begin
      w_src_val = r_a;
      w_dst_val = r_a;
      case (r_src)
         2'd0:    w_src_val = r_a;
         2'd1:    w_src_val = r_x;
         2'd2:    w_src_val = r_y;
         default: w_src_val = r_s;
      endcase
      case (r_dst)
         2'd0:    w_dst_val = r_a;
         2'd1:    w_dst_val = r_x;
         2'd2:    w_dst_val = r_y;
         default: w_dst_val = r_s;
      endcase
   end

   // Binary result, carry and overflow of the captured op
   always_comb begin
      w_res = '0;
      w_c   = r_p[0];
      w_v   = r_p[6];
      case (r_code)
         OP_LD:  w_res = r_opnd;
         OP_TR:  w_res = w_src_val;
         OP_ADC, OP_SBC: begin
            w_res = w_sum[DW-1:0];
            w_c   = w_sum[DW];
            w_v   = (r_a[DW-1] == w_addend[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);
         end
         OP_AND: w_res = r_a & r_opnd;
         OP_ORA: w_res = r_a | r_opnd;
         OP_EOR: w_res = r_a ^ r_opnd;
         OP_CMP: begin
            w_res = w_src_val - r_opnd;
            w_c   = (w_src_val >= r_opnd);
         end
         OP_ASL: begin
            w_res = {w_dst_val[DW-2:0], 1'b0};
            w_c   = w_dst_val[DW-1];
         end
         OP_LSR: begin
            w_res = {1'b0, w_dst_val[DW-1:1]};
            w_c   = w_dst_val[0];
         end
         OP_ROL: begin
            w_res = {w_dst_val[DW-2:0], r_p[0]};
            w_c   = w_dst_val[DW-1];
         end
         OP_ROR: begin
            w_res = {r_p[0], w_dst_val[DW-1:1]};
            w_c   = w_dst_val[0];
         end
         OP_INC: w_res = w_dst_val + ONE;
         OP_DEC: w_res = w_dst_val - ONE;
         default: w_res = '0;
      endcase
   end

   // Write-back decode: which register and which flag groups the op updates
   always_comb begin
      w_wr_en  = 1'b0;
      w_wr_sel = r_dst;
      w_nz_en  = 1'b0;
      w_c_en   = 1'b0;
      w_v_en   = 1'b0;
      case (r_code)
         OP_LD: begin
            w_wr_en = 1'b1;
            w_nz_en = 1'b1;
         end
         OP_TR: begin
            w_wr_en = 1'b1;
            w_nz_en = (r_dst != 2'd3);
         end
         OP_ADC, OP_SBC: begin
            w_wr_en  = 1'b1;
            w_wr_sel = 2'd0;
            w_nz_en  = 1'b1;
            w_c_en   = 1'b1;
            w_v_en   = 1'b1;
         end
         OP_AND, OP_ORA, OP_EOR: begin
            w_wr_en  = 1'b1;
            w_wr_sel = 2'd0;
            w_nz_en  = 1'b1;
         end
         OP_CMP: begin
            w_nz_en = 1'b1;
            w_c_en  = 1'b1;
         end
         OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
            w_wr_en = 1'b1;
            w_nz_en = 1'b1;
            w_c_en  = 1'b1;
         end
         OP_INC, OP_DEC: begin
            w_wr_en = 1'b1;
            w_nz_en = 1'b1;
         end
         default: w_wr_en = 1'b0;
      endcase
   end

   // Sequencer FSM, hold registers, architectural state and completion pulses
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_s     <= '1;
         r_p     <= 8'h20;
         r_code  <= 4'd0;
         r_src   <= 2'd0;
         r_dst   <= 2'd0;
         r_opnd  <= '0;
         r_res   <= '0;
         r_c     <= 1'b0;
         r_v     <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (op_valid) begin
                  r_code  <= op_code;
                  r_src   <= op_src;
                  r_dst   <= op_dst;
                  r_opnd  <= op_operand;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_res   <= w_res;
               r_c     <= w_c;
               r_v     <= w_v;
               r_state <= w_dec_go ? ST_DADJ : ST_WB;
            end
            ST_DADJ: begin
               // V stays from the binary sum; result and C come from the decimal correction
               r_res   <= w_bcd[DW-1:0];
               r_c     <= w_bcd[DW];
               r_state <= ST_WB;
            end
            ST_WB: begin
               if (w_wr_en) begin
                  case (w_wr_sel)
                     2'd0:    r_a <= r_res;
                     2'd1:    r_x <= r_res;
                     2'd2:    r_y <= r_res;
                     default: r_s <= r_res;
                  endcase
               end
               if (w_nz_en) begin
                  r_p[7] <= r_res[DW-1];
                  r_p[1] <= (r_res == '0);
               end
               if (w_c_en) r_p[0] <= r_c;
               if (w_v_en) r_p[6] <= r_v;
               if ((r_code == OP_FLG) && (r_opnd[2:0] != 3'd5)) r_p[r_opnd[2:0]] <= r_opnd[DW-1];
               r_done  <= 1'b1;
               r_err   <= (r_code == OP_RSV);
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Bench for cpu_exec_unit: three variants (8-bit binary, 8-bit decimal, 16-bit binary)
// driven by directed and $urandom ops and checked against an arithmetic reference model.
module tb_cpu_exec_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  op_code;
   logic [1:0]  op_src, op_dst;
   logic [15:0] op_operand;
   logic [2:0]  vld, rdy, done, err;
   logic [7:0]  a0, x0, y0, s0, p0, a1, x1, y1, s1, p1, p2;
   logic [15:0] a2, x2, y2, s2;

   logic [15:0] d_reg [3][4];
   logic [7:0]  d_p [3];

   int n_chk = 0;
   int n_err = 0;
   int m_reg [3][4];
   int m_p [3];
   int last_lat;
   int last_err;

   cpu_exec_unit #(.DW(8), .DECIMAL_EN(1'b0)) u_dut_bin8 (
      .clk_ph1(clk), .rst(rst), .op_valid(vld[0]), .op_ready(rdy[0]),
      .op_code(op_code), .op_src(op_src), .op_dst(op_dst), .op_operand(op_operand[7:0]),
      .op_done(done[0]), .op_err(err[0]),
      .a_out(a0), .x_out(x0), .y_out(y0), .s_out(s0), .p_out(p0));

   cpu_exec_unit #(.DW(8), .DECIMAL_EN(1'b1)) u_dut_dec8 (
      .clk_ph1(clk), .rst(rst), .op_valid(vld[1]), .op_ready(rdy[1]),
      .op_code(op_code), .op_src(op_src), .op_dst(op_dst), .op_operand(op_operand[7:0]),
      .op_done(done[1]), .op_err(err[1]),
      .a_out(a1), .x_out(x1), .y_out(y1), .s_out(s1), .p_out(p1));

   cpu_exec_unit #(.DW(16), .DECIMAL_EN(1'b0)) u_dut_bin16 (
      .clk_ph1(clk), .rst(rst), .op_valid(vld[2]), .op_ready(rdy[2]),
      .op_code(op_code), .op_src(op_src), .op_dst(op_dst), .op_operand(op_operand),
      .op_done(done[2]), .op_err(err[2]),
      .a_out(a2), .x_out(x2), .y_out(y2), .s_out(s2), .p_out(p2));

   assign d_reg[0][0] = {8'h00, a0};
   assign d_reg[0][1] = {8'h00, x0};
   assign d_reg[0][2] = {8'h00, y0};
   assign d_reg[0][3] = {8'h00, s0};
   assign d_reg[1][0] = {8'h00, a1};
   assign d_reg[1][1] = {8'h00, x1};
   assign d_reg[1][2] = {8'h00, y1};
   assign d_reg[1][3] = {8'h00, s1};
   assign d_reg[2][0] = a2;
   assign d_reg[2][1] = x2;
   assign d_reg[2][2] = y2;
   assign d_reg[2][3] = s2;
   assign d_p[0] = p0;
   assign d_p[1] = p1;
   assign d_p[2] = p2;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int width_of(input int inst);
      return (inst == 2) ? 16 : 8;
   endfunction

   function automatic int sgn(input int v, input int w);
      return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
   endfunction

   function automatic int bcd2int(input int v, input int w);
      int r = 0;
      int m = 1;
      for (int i = 0; i < w / 4; i++) begin
         r += ((v >> (4 * i)) & 15) * m;
         m *= 10;
      end
      return r;
   endfunction

   function automatic int int2bcd(input int d, input int w);
      int r = 0;
      for (int i = 0; i < w / 4; i++) begin
         r |= (d % 10) << (4 * i);
         d /= 10;
      end
      return r;
   endfunction

   function automatic bit is_bcd(input int v, input int w);
      for (int i = 0; i < w / 4; i++)
         if (((v >> (4 * i)) & 15) > 9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int rand_bcd(input int w);
      int r = 0;
      for (int i = 0; i < w / 4; i++) r = r * 10 + $urandom_range(0, 9);
      return int2bcd(r, w);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_reg[i][0] = 0;
         m_reg[i][1] = 0;
         m_reg[i][2] = 0;
         m_reg[i][3] = (1 << width_of(i)) - 1;
         m_p[i] = 'h20;
      end
   endtask

   // Architectural effect of one op, from the op table and plain integer arithmetic
   task automatic model_op(input int inst, input int code, input int src, input int dst, input int opnd);
      int w, mask, msb, c, a, sv, dv, res, tgt, newc, newv, s, d, lim;
      bit wr, nz, setc, setv;
      w = width_of(inst); mask = (1 << w) - 1; msb = 1 << (w - 1);
      c = m_p[inst] & 1; a = m_reg[inst][0]; sv = m_reg[inst][src]; dv = m_reg[inst][dst];
      wr = 0; nz = 0; setc = 0; setv = 0; tgt = dst; res = 0; newc = 0; newv = 0;
      case (code)
         0: begin res = opnd; wr = 1; nz = 1; end
         1: begin res = sv; wr = 1; nz = (dst != 3); end
         2, 3: begin
            tgt = 0; wr = 1; nz = 1; setc = 1; setv = 1;
            if (code == 2) begin
               res = (a + opnd + c) & mask; newc = (a + opnd + c) > mask;
               s = sgn(a, w) + sgn(opnd, w) + c;
            end else begin
               res = (a - opnd - (1 - c)) & mask; newc = (a - opnd - (1 - c)) >= 0;
               s = sgn(a, w) - sgn(opnd, w) - (1 - c);
            end
            newv = (s >= msb) || (s < -msb);
            if (inst == 1 && m_p[inst][3]) begin
               lim = 10 ** (w / 4);
               if (code == 2) begin
                  d = bcd2int(a, w) + bcd2int(opnd, w) + c;
                  newc = d >= lim;
                  d = d % lim;
               end else begin
                  d = bcd2int(a, w) - bcd2int(opnd, w) - (1 - c);
                  newc = d >= 0;
                  if (d < 0) d += lim;
               end
               res = int2bcd(d, w);
            end
         end
         4: begin res = a & opnd; tgt = 0; wr = 1; nz = 1; end
         5: begin res = a | opnd; tgt = 0; wr = 1; nz = 1; end
         6: begin res = a ^ opnd; tgt = 0; wr = 1; nz = 1; end
         7: begin res = (sv - opnd) & mask; nz = 1; setc = 1; newc = sv >= opnd; end
         8: begin res = (dv * 2) & mask; newc = dv >= msb; wr = 1; nz = 1; setc = 1; end
         9: begin res = dv / 2; newc = dv % 2; wr = 1; nz = 1; setc = 1; end
         10: begin res = ((dv * 2) & mask) + c; newc = dv >= msb; wr = 1; nz = 1; setc = 1; end
         11: begin res = dv / 2 + c * msb; newc = dv % 2; wr = 1; nz = 1; setc = 1; end
         12: begin res = (dv + 1) & mask; wr = 1; nz = 1; end
         13: begin res = (dv + mask) & mask; wr = 1; nz = 1; end
         14: if ((opnd & 7) != 5) m_p[inst][opnd & 7] = (opnd >= msb);
         default: ;
      endcase
      if (wr) m_reg[inst][tgt] = res;
      if (nz) begin
         m_p[inst][7] = (res >= msb);
         m_p[inst][1] = (res == 0);
      end
      if (setc) m_p[inst][0] = newc[0];
      if (setv) m_p[inst][6] = newv[0];
   endtask

   task automatic compare_state(input int inst, input string tag);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("%s_reg%0d", tag, i), 32'(d_reg[inst][i]), 32'(m_reg[inst][i]));
      check_val($sformatf("%s_p", tag), 32'(d_p[inst]), 32'(m_p[inst]));
   endtask

   // Issue one op, scramble inputs after acceptance, wait for op_done, check against the model
   task automatic run_op(input int inst, input int code, input int src, input int dst,
                         input int opnd, input string tag);
      int t, exp_lat;
      exp_lat = (inst == 1 && m_p[1][3] == 1 && (code == 2 || code == 3)) ? 4 : 3;
      @(negedge clk);
      op_code = code[3:0]; op_src = src[1:0]; op_dst = dst[1:0]; op_operand = opnd[15:0];
      vld[inst] = 1'b1;
      t = 0;
      while (!rdy[inst] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!rdy[inst]) begin
         check_val({tag, "_ready_timeout"}, 32'(rdy[inst]), 32'd1);
         vld[inst] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      vld[inst] = 1'b0;
      op_code = 4'($urandom); op_src = 2'($urandom); op_dst = 2'($urandom); op_operand = 16'($urandom);
      last_lat = 0;
      do begin
         @(negedge clk);
         last_lat++;
      end while (!done[inst] && last_lat < 20);
      last_err = int'(err[inst]);
      model_op(inst, code, src, dst, opnd);
      check_val({tag, "_latency"}, 32'(last_lat), 32'(exp_lat));
      check_val({tag, "_err"}, 32'(last_err), (code == 15) ? 32'd1 : 32'd0);
      compare_state(inst, tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int last, nacc, mask, code, src, dst, opnd;
      vld = 3'b000; rst = 1'b0;
      op_code = 4'd0; op_src = 2'd0; op_dst = 2'd0; op_operand = 16'd0;
      model_reset();

      @(negedge clk); @(negedge clk);
      check_val("rst_ready_low", 32'(rdy), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_ready_high", 32'(rdy), 32'd7);
      check_val("rst_s_ff", 32'(s0), 32'hFF);
      check_val("rst_p_20", 32'(p0), 32'h20);
      for (int i = 0; i < 3; i++) compare_state(i, $sformatf("rst%0d", i));

      // Reset while an ADC is in flight abandons it
      run_op(0, 0, 0, 0, 'h50, "ld_a50");
      @(negedge clk);
      op_code = 4'd2; op_operand = 16'h0011; vld[0] = 1'b1;
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rstfl_ready0", 32'(rdy[0]), 32'd0);
      check_val("rstfl_done0", 32'(done[0]), 32'd0);
      @(negedge clk);
      check_val("rstfl_done1", 32'(done[0]), 32'd0);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      check_val("rstfl_ready", 32'(rdy[0]), 32'd1);
      check_val("rstfl_done", 32'(done[0]), 32'd0);
      check_val("rstfl_a", 32'(a0), 32'h00);
      compare_state(0, "rstfl");

      // Binary ADC with signed overflow
      run_op(0, 0, 0, 0, 'h50, "adc_ld");
      run_op(0, 14, 0, 0, 'h00, "adc_clc");
      run_op(0, 2, 0, 0, 'h50, "adc");
      check_val("adc_a", 32'(a0), 32'hA0);
      check_val("adc_nvzc", 32'({p0[7], p0[6], p0[1], p0[0]}), 32'b1100);
      check_val("adc_lat", 32'(last_lat), 32'd3);

      // SBC borrow, then CMP equal
      run_op(0, 14, 0, 0, 'h80, "sbc_sec");
      run_op(0, 0, 0, 0, 'h00, "sbc_ld");
      run_op(0, 3, 0, 0, 'h01, "sbc");
      check_val("sbc_a", 32'(a0), 32'hFF);
      check_val("sbc_nc", 32'({p0[7], p0[0]}), 32'b10);
      run_op(0, 0, 0, 1, 'h10, "cmp_ldx");
      run_op(0, 7, 1, 0, 'h10, "cmp");
      check_val("cmp_zc", 32'({p0[1], p0[0]}), 32'b11);
      check_val("cmp_x", 32'(x0), 32'h10);

      // Rotate through carry and decrement wrap
      run_op(0, 0, 0, 2, 'h81, "rot_ldy");
      run_op(0, 14, 0, 0, 'h00, "rot_clc");
      run_op(0, 10, 0, 2, 0, "rol");
      check_val("rol_y", 32'(y0), 32'h02);
      check_val("rol_c", 32'(p0[0]), 32'd1);
      run_op(0, 11, 0, 2, 0, "ror");
      check_val("ror_y", 32'(y0), 32'h81);
      check_val("ror_c", 32'(p0[0]), 32'd0);
      run_op(0, 0, 0, 1, 'h00, "dec_ldx");
      run_op(0, 14, 0, 0, 'h80, "dec_sec");
      run_op(0, 13, 0, 1, 0, "dec");
      check_val("dec_x", 32'(x0), 32'hFF);
      check_val("dec_nc", 32'({p0[7], p0[0]}), 32'b11);

      // D flag with and without decimal support
      for (int i = 0; i < 2; i++) begin
         run_op(i, 14, 0, 0, 'h83, $sformatf("dm%0d_sed", i));
         run_op(i, 0, 0, 0, 'h58, $sformatf("dm%0d_ld", i));
         run_op(i, 14, 0, 0, 'h00, $sformatf("dm%0d_clc", i));
         run_op(i, 2, 0, 0, 'h46, $sformatf("dm%0d_adc", i));
      end
      check_val("bin_adc_a", 32'(a0), 32'h9E);
      check_val("bin_adc_c", 32'(p0[0]), 32'd0);
      check_val("dec_adc_a", 32'(a1), 32'h04);
      check_val("dec_adc_c", 32'(p1[0]), 32'd1);
      check_val("dec_adc_lat", 32'(last_lat), 32'd4);

      // Reserved op: error pulse with done, one cycle wide, no state change
      run_op(0, 15, 1, 2, 'hFF, "rsv");
      check_val("rsv_err", 32'(last_err), 32'd1);
      @(negedge clk);
      check_val("rsv_pulse", 32'({done[0], err[0]}), 32'd0);

      // 16-bit increment wrap
      run_op(2, 0, 0, 1, 'hFFFF, "w16_ld");
      run_op(2, 12, 0, 1, 0, "w16_inc");
      check_val("w16_x", 32'(x2), 32'h0000);
      check_val("w16_z", 32'(p2[1]), 32'd1);

      // op_valid held high: one acceptance every 3 cycles, each adding exactly 1
      run_op(0, 0, 0, 0, 'hFD, "b2b_ld");
      @(negedge clk);
      op_code = 4'd12; op_dst = 2'd0; op_src = 2'd0; vld[0] = 1'b1;
      last = -1; nacc = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (rdy[0]) begin
            if (last >= 0) check_val("b2b_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            nacc++;
         end
         @(negedge clk);
      end
      vld[0] = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nacc; i++) model_op(0, 12, 0, 0, 0);
      check_val("b2b_count", 32'(nacc), 32'd5);
      check_val("b2b_a", 32'(a0), 32'h02);
      compare_state(0, "b2b");

      // Randomized ops; decimal unit only sees BCD operands while D is set
      run_op(1, 14, 0, 0, 'h83, "rnd_sed");
      for (int inst = 0; inst < 3; inst++) begin
         mask = (1 << width_of(inst)) - 1;
         for (int k = 0; k < 40; k++) begin
            code = $urandom_range(0, 15);
            src  = $urandom_range(0, 3);
            dst  = $urandom_range(0, 3);
            opnd = $urandom & mask;
            if (inst == 1 && m_p[1][3] == 1 && (code == 2 || code == 3)) begin
               if (!is_bcd(m_reg[1][0], 8)) run_op(1, 0, 0, 0, rand_bcd(8), "rnd_ldbcd");
               opnd = rand_bcd(8);
            end
            run_op(inst, code, src, dst, opnd, $sformatf("rnd%0d_%0d_op%0d", inst, k, code));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
